// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared constants and lane helper for the 2-D IDCT datapath
package idct_pkg;

  localparam int IDCT_N     = 8;
  localparam int IDCT_W     = 8;
  localparam int IDCT_ROW_W = IDCT_N * IDCT_W;

  function automatic logic [IDCT_W-1:0] idct_lane(input logic [IDCT_ROW_W-1:0] vec,
                                                  input int unsigned           idx);
    return vec[idx*IDCT_W +: IDCT_W];
  endfunction

endpackage

// File: rtl/idct_tbank.sv
// rtl/idct_tbank.sv - one N x N*W transpose bank: row write port, column read mux
module idct_tbank
  import idct_pkg::*;
#(
  parameter int N = IDCT_N,
  parameter int W = IDCT_W
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] wrow_i,
  input  logic [N*W-1:0]       wdata_i,
  input  logic [$clog2(N)-1:0] col_i,
  output logic [N*W-1:0]       rdata_o
);

  // Data storage only; validity lives in the owner's full flags, so no reset.
  logic [N*W-1:0] mem_q [N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wrow_i] <= wdata_i;
    end
  end

  // Output lane r is element col_i of stored row r.
  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < N; r++) begin
      rdata_o[r*W +: W] = mem_q[r][col_i*W +: W];
    end
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// rtl/idct_transpose_buf.sv - ping-pong 8x8 transpose buffer between row and column IDCT passes
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int N = IDCT_N,
  parameter int W = IDCT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [N*W-1:0] data_in,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] data_out
);

  localparam int CW = $clog2(N);

  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [CW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [1:0]    full_q, full_d;

  logic wr_fire;
  logic rd_fire;

  assign s_ready = ~full_q[wb_q];
  assign m_valid = full_q[rb_q];
  assign wr_fire = s_valid & s_ready;
  assign rd_fire = m_valid & m_ready;

  // Set and clear in the same cycle always hit different banks, so both apply.
  always_comb begin
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    full_d   = full_q;
    if (wr_fire) begin
      if (wr_row_q == CW'(N-1)) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_row_d     = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_col_q == CW'(N-1)) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rd_col_d     = '0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
      full_q   <= 2'b00;
    end else begin
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
      full_q   <= full_d;
    end
  end

  logic [N*W-1:0] bank_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    idct_tbank #(
      .N(N),
      .W(W)
    ) u_bank (
      .clk_i  (clk),
      .we_i   (wr_fire && (wb_q == 1'(b))),
      .wrow_i (wr_row_q),
      .wdata_i(data_in),
      .col_i  (rd_col_q),
      .rdata_o(bank_rdata[b])
    );
  end

  assign data_out = m_valid ? bank_rdata[rb_q] : '0;

endmodule
